gbt_frame_rx_decoder: RTL
=========================

Name: gbt_frame_rx_decoder

Overview:
Receive-side decoder for the MCOI GBT payload link; it is the counterpart of the frame packer that fills gbt_data_x.data_sent on the far end.
- Takes 80-bit words from gbtbank_gbt_data_o (gbt_data_x.data_received) in the 40 MHz frame clock domain.
- Validates header, sequence number and CRC-8 on each word.
- Runs a HUNT/LOCKING/LOCKED acquisition FSM.
- Delivers 56-bit payloads with a valid strobe to McoiXu5System, plus link status and error counters.

Parameters:
SYNC_HDR, 8'hA5, required value of frame bits [79:72]
LOCK_FRAMES, 4, consecutive good, in-sequence frames needed to reach LOCKED (1..15)
UNLOCK_ERRORS, 3, consecutive bad frames in LOCKED that force HUNT (1..15)
CNT_W, 16, width of the saturating error counters

Ports:
clk_ik  in  1  40 MHz frame clock (ClkRs40MHzMGMT)
rst_inr  in  1  asynchronous active-low reset
rx_ready_i  in  1  gbtbank_gbtrx_ready_o; treated as asynchronous to frame validity, already synchronous to clk_ik
frame_en_i  in  1  qualifies data_i; one frame per asserted cycle
data_i  in  80  received GBT frame
payload_o  out  56  frame bits [63:8] of the last delivered frame
payload_valid_o  out  1  one-cycle strobe, payload_o valid
seq_o  out  8  sequence number of the delivered frame
locked_o  out  1  high in LOCKED
crc_err_cnt_o  out  CNT_W  bad frames (header or CRC), saturating
seq_err_cnt_o  out  CNT_W  sequence discontinuities in LOCKED, saturating
cnt_clear_i  in  1  synchronous clear of both counters

Behaviour:
Frame format:
- [79:72] header.
- [71:64] seq, incremented modulo 256 per frame by the sender.
- [63:8] payload.
- [7:0] CRC-8: poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, computed MSB-first over bits [79:8].

Definitions:
- Good frame: header == SYNC_HDR and CRC matches.
- Bad frame: anything else.

Pipeline:
- Stage 1 registers data_i/frame_en_i.
- Stage 2 computes the CRC and checks, updates the FSM, counters and outputs.
- payload_valid_o asserts exactly 2 clk_ik cycles after the frame_en_i cycle carrying the frame.

Reset (rst_inr low, asynchronous):
- All outputs 0, FSM in HUNT, good_cnt = 0, bad_cnt = 0, exp_seq = 0.
- Pipeline registers are cleared.

rx_ready_i low:
- FSM goes to HUNT on the next cycle and the pipeline valid is flushed.
- No counters increment.
- In-flight frames are not delivered.

FSM:
- HUNT:
  - Good frame → LOCKING; good_cnt = 1; exp_seq = seq+1.
  - Bad frame → stay, no count.
  - If LOCK_FRAMES == 1, go directly to LOCKED.
- LOCKING:
  - Good frame with seq == exp_seq → good_cnt+1. When good_cnt reaches LOCK_FRAMES → LOCKED.
  - Good frame with seq ≠ exp_seq → good_cnt = 1, resync exp_seq.
  - Bad frame → HUNT.
  - No payload is delivered in HUNT or LOCKING.
- LOCKED:
  - Good frame → deliver payload_o/seq_o with payload_valid_o = 1; bad_cnt = 0; exp_seq = seq+1.
  - If seq ≠ exp_seq on a good frame, seq_err_cnt increments and the payload is still delivered.
  - Bad frame → crc_err_cnt increments, no delivery, bad_cnt+1. When bad_cnt reaches UNLOCK_ERRORS → HUNT and locked_o drops the same cycle.

Counters and outputs:
- Counters saturate at all-ones with no wrap.
- cnt_clear_i has priority over a simultaneous increment: the result is 0.
- crc_err_cnt counts only in LOCKED.
- exp_seq wraps 255→0; that transition is not an error.
- payload_o/seq_o hold their value between strobes.

Optional Feature:
Macro GBT_RX_LOST_FRAME_CNT_EN.
- Defined:
  - Adds output lost_frames_cnt_o [CNT_W].
  - In LOCKED, on a good frame with seq ≠ exp_seq, it adds (seq − exp_seq) mod 256, saturating.
  - It is cleared by reset and by cnt_clear_i.
- Undefined: the port is absent and there is no logic.

Test Plan:
- Reset release, rx_ready_i = 1, 6 good frames seq 0..5 payload 56'h0123456789ABCD → locked_o high after 4th frame + 2 cycles; payload_valid_o on frames 5,6 only; seq_o = 4,5.
- Locked, sequence 254,255,0,1 → 4 strobes, seq_err_cnt_o stays 0 (wrap accepted).
- Locked, frame with CRC byte XOR 0x01, then good frames → crc_err_cnt_o = 1, no strobe for that frame, locked_o stays 1; three consecutive bad frames → locked_o falls on 3rd, crc_err_cnt_o = 4.
- Locked at seq 10, next good frame seq 13 → strobe delivered, seq_err_cnt_o = 1; with GBT_RX_LOST_FRAME_CNT_EN, lost_frames_cnt_o = 2.
- Locked, deassert rx_ready_i for 1 cycle mid-stream → locked_o = 0 next cycle, no counter change, relock after 4 good frames.
- Force counter to 16'hFFFF, apply bad frame → stays 16'hFFFF; assert cnt_clear_i with a simultaneous bad frame → counter 0.

Source files
------------

// File: rtl/gbt_frame_rx_decoder.sv
// gbt_frame_rx_decoder
// Receive-side decoder for the MCOI GBT payload link. It checks the header,
// sequence number and CRC-8 of each 80-bit frame, acquires frame lock with a
// HUNT/LOCKING/LOCKED state machine, and delivers 56-bit payloads with a valid
// strobe. It also keeps saturating counters of bad frames and of sequence
// errors.
//
// Frame layout: [79:72] header, [71:64] seq, [63:8] payload, [7:0] CRC-8
// (poly 0x07, init 0x00, MSB first over [79:8]).
//
// Optional build macro GBT_RX_LOST_FRAME_CNT_EN adds lost_frames_cnt_o. In
// LOCKED, each good frame with an unexpected sequence number adds the size of
// the sequence gap to this counter.
//
// State table:
//   state      | meaning
//   ST_HUNT    | searching for a good frame, no delivery
//   ST_LOCKING | counting consecutive in-sequence good frames, no delivery
//   ST_LOCKED  | delivering payloads, counting errors

module gbt_frame_rx_decoder #(
  parameter logic [7:0]  SYNC_HDR      = 8'hA5,
  parameter int unsigned LOCK_FRAMES   = 4,
  parameter int unsigned UNLOCK_ERRORS = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_ik,
  input  logic             rst_inr,
  input  logic             rx_ready_i,
  input  logic             frame_en_i,
  input  logic [79:0]      data_i,
  output logic [55:0]      payload_o,
  output logic             payload_valid_o,
  output logic [7:0]       seq_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] crc_err_cnt_o,
  output logic [CNT_W-1:0] seq_err_cnt_o,
`ifdef GBT_RX_LOST_FRAME_CNT_EN
  output logic [CNT_W-1:0] lost_frames_cnt_o,
`endif
  input  logic             cnt_clear_i
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_ERRORS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // CRC-8, poly x^8+x^2+x+1, MSB first, init 0, no reflection or final xor
  function automatic logic [7:0] crc8(input logic [71:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 71; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // stage 1
  logic        s1_valid_q, s1_valid_d;
  logic [79:0] s1_data_q, s1_data_d;

  // FSM and tracking state
  state_e      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic [7:0]  exp_seq_q, exp_seq_d;

  // outputs
  logic [55:0]      payload_q, payload_d;
  logic [7:0]       seq_q, seq_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] crc_cnt_q, crc_cnt_d;
  logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;

  // stage 2 decode
  logic [7:0]  s1_hdr;
  logic [7:0]  s1_seq;
  logic [55:0] s1_payload;
  logic [7:0]  s1_crc;
  logic        frame_good;
  logic        deliver;
  logic        crc_inc;
  logic        seq_mis;
  logic [3:0]  good_inc;
  logic [3:0]  bad_inc;

  // A frame captured while the link is not ready is dropped at the door.
  always_comb begin
    s1_valid_d = frame_en_i & rx_ready_i;
    s1_data_d  = frame_en_i ? data_i : s1_data_q;
  end

  // Stage 1 register.
  always_ff @(posedge clk_ik or negedge rst_inr) begin
    if (!rst_inr) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // Split the staged frame into its fields and judge header and CRC.
  always_comb begin
    s1_hdr     = s1_data_q[79:72];
    s1_seq     = s1_data_q[71:64];
    s1_payload = s1_data_q[63:8];
    s1_crc     = s1_data_q[7:0];
    frame_good = (s1_hdr == SYNC_HDR) && (crc8(s1_data_q[79:8]) == s1_crc);
    good_inc   = good_cnt_q + 4'd1;
    bad_inc    = bad_cnt_q + 4'd1;
  end

  // Acquisition FSM next state, plus the per-frame delivery/error events.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    exp_seq_d  = exp_seq_q;
    deliver    = 1'b0;
    crc_inc    = 1'b0;
    seq_mis    = 1'b0;
    if (!rx_ready_i) begin
      // Losing the link aborts acquisition and discards the in-flight frame.
      state_d    = ST_HUNT;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
    end else if (s1_valid_q) begin
      case (state_q)
        ST_HUNT: begin
          if (frame_good) begin
            good_cnt_d = 4'd1;
            exp_seq_d  = s1_seq + 8'd1;
            if (LOCK_N <= 4'd1) begin
              state_d   = ST_LOCKED;
              bad_cnt_d = 4'd0;
            end else begin
              state_d = ST_LOCKING;
            end
          end
        end
        ST_LOCKING: begin
          if (frame_good) begin
            exp_seq_d = s1_seq + 8'd1;
            if (s1_seq == exp_seq_q) begin
              good_cnt_d = good_inc;
              if (good_inc >= LOCK_N) begin
                state_d   = ST_LOCKED;
                bad_cnt_d = 4'd0;
              end
            end else begin
              // Out-of-order good frame restarts the run from this frame.
              good_cnt_d = 4'd1;
            end
          end else begin
            state_d    = ST_HUNT;
            good_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (frame_good) begin
            deliver   = 1'b1;
            seq_mis   = (s1_seq != exp_seq_q);
            bad_cnt_d = 4'd0;
            exp_seq_d = s1_seq + 8'd1;
          end else begin
            crc_inc   = 1'b1;
            bad_cnt_d = bad_inc;
            if (bad_inc >= UNLOCK_N) begin
              state_d    = ST_HUNT;
              good_cnt_d = 4'd0;
              bad_cnt_d  = 4'd0;
            end
          end
        end
        default: begin
          state_d    = ST_HUNT;
          good_cnt_d = 4'd0;
          bad_cnt_d  = 4'd0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_ik or negedge rst_inr) begin
    if (!rst_inr) begin
      state_q    <= ST_HUNT;
      good_cnt_q <= 4'd0;
      bad_cnt_q  <= 4'd0;
      exp_seq_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      exp_seq_q  <= exp_seq_d;
    end
  end

  // Delivered payload/seq hold between strobes; counters saturate, clear wins.
  always_comb begin
    valid_d   = deliver;
    payload_d = deliver ? s1_payload : payload_q;
    seq_d     = deliver ? s1_seq : seq_q;
    crc_cnt_d = crc_cnt_q;
    seq_cnt_d = seq_cnt_q;
    if (cnt_clear_i) begin
      crc_cnt_d = '0;
      seq_cnt_d = '0;
    end else begin
      if (crc_inc && (crc_cnt_q != CNT_MAX)) crc_cnt_d = crc_cnt_q + CNT_W'(1);
      if (seq_mis && (seq_cnt_q != CNT_MAX)) seq_cnt_d = seq_cnt_q + CNT_W'(1);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk_ik or negedge rst_inr) begin
    if (!rst_inr) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      seq_q     <= 8'd0;
      crc_cnt_q <= '0;
      seq_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      seq_q     <= seq_d;
      crc_cnt_q <= crc_cnt_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

`ifdef GBT_RX_LOST_FRAME_CNT_EN
  // Sum is wide enough for the counter plus an 8-bit gap without overflow.
  localparam int unsigned SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;

  logic [7:0]       seq_gap;
  logic [SUM_W-1:0] lost_sum;
  logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;

  // Accumulate the number of frames skipped by a sequence jump, saturating.
  always_comb begin
    seq_gap    = s1_seq - exp_seq_q;
    lost_sum   = SUM_W'(lost_cnt_q) + SUM_W'(seq_gap);
    lost_cnt_d = lost_cnt_q;
    if (cnt_clear_i) begin
      lost_cnt_d = '0;
    end else if (seq_mis) begin
      lost_cnt_d = (lost_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(lost_sum);
    end
  end

  // Lost-frame counter register.
  always_ff @(posedge clk_ik or negedge rst_inr) begin
    if (!rst_inr) lost_cnt_q <= '0;
    else          lost_cnt_q <= lost_cnt_d;
  end

  assign lost_frames_cnt_o = lost_cnt_q;
`endif

  assign payload_o       = payload_q;
  assign payload_valid_o = valid_q;
  assign seq_o           = seq_q;
  assign locked_o        = (state_q == ST_LOCKED);
  assign crc_err_cnt_o   = crc_cnt_q;
  assign seq_err_cnt_o   = seq_cnt_q;

endmodule
